// File: rtl/decoder_pkg.sv
// Shared types and helpers for the N-to-2^N scanning decoder.
package decoder_pkg;

    // Top-level controller states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_e;

    // Widest select the helper supports; callers truncate the result to their width.
    localparam int MAX_SEL_W = 8;
    localparam int MAX_OUT_W = 1 << MAX_SEL_W;

    // One-hot image of idx, active-high, MAX_OUT_W bits wide.
    function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] idx);
        logic [MAX_OUT_W-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/decoder_nto2n_scan_dwell_timer.sv
// Down-counter holding the remaining dwell cycles of the current scan index.
// Priority: clr over load over dec; dec never underflows.
module dwell_timer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               load,
    input  logic               dec,
    input  logic [DWELL_W-1:0] load_val,
    output logic               zero
);

    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] cnt_d;

    // Next count: clear, reload, or step down towards zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/decoder_nto2n_scan.sv
// Registered N-to-2^N one-hot decoder with a handshaked direct mode and an
// autonomous scan mode that walks every line with a programmable dwell.
//
// Handshake: a select word is taken on a rising clk edge when sel_valid and
// sel_ready are both high; sel_ready depends only on en, mode and rst_n,
// never on sel_valid, and a valid word offered while sel_ready is low is
// simply not taken (the source may drop or change it).
module decoder_nto2n_scan
    import decoder_pkg::*;
#(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 8,
    parameter int ACT_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  sel_valid,
    output logic                  sel_ready,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [(2**SEL_W)-1:0] y,
    output logic [SEL_W-1:0]      cur_idx,
    output logic                  active,
    output logic                  wrap
);

    localparam int OUT_W = 2 ** SEL_W;
    localparam logic [OUT_W-1:0] POL_MASK = (ACT_LOW != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

    state_e           state_q, state_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [OUT_W-1:0] y_q, y_d;     // active-high image; polarity applied at the pin
    logic             wrap_q, wrap_d;

    logic tmr_clr, tmr_load, tmr_dec, tmr_zero;
    logic handshake;

    assign sel_ready = en & ~mode & rst_n;
    assign handshake = sel_valid & sel_ready;

    dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (tmr_clr),
        .load     (tmr_load),
        .dec      (tmr_dec),
        .load_val (dwell),
        .zero     (tmr_zero)
    );

    // Next state, index, output image and timer control. en dominates mode.
    // y_d is always derived from idx_d, so it can only ever be one-hot or all-off.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        y_d      = y_q;
        wrap_d   = 1'b0;
        tmr_clr  = 1'b0;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        if (!en) begin
            state_d = IDLE;
            y_d     = '0;
            tmr_clr = 1'b1;
        end else if (mode) begin
            if (state_q != SCAN) begin
                state_d  = SCAN;
                idx_d    = '0;
                tmr_load = 1'b1;
            end else if (tmr_zero) begin
                idx_d    = idx_q + 1'b1;
                tmr_load = 1'b1;
                wrap_d   = &idx_q;
            end else begin
                tmr_dec = 1'b1;
            end
            y_d = OUT_W'(onehot(MAX_SEL_W'(idx_d)));
        end else begin
            tmr_clr = 1'b1;
            if (handshake) begin
                state_d = DIRECT;
                idx_d   = sel;
                y_d     = OUT_W'(onehot(MAX_SEL_W'(sel)));
            end else if (state_q == SCAN) begin
                state_d = IDLE;
                y_d     = '0;
            end
        end
    end

    // State, index, output and wrap registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            y_q     <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            y_q     <= y_d;
            wrap_q  <= wrap_d;
        end
    end

    assign y       = y_q ^ POL_MASK;
    assign cur_idx = idx_q;
    assign active  = (state_q != IDLE);
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_decoder_nto2n_scan.sv
// Self-checking bench for decoder_nto2n_scan: default instance checked every
// cycle against a behavioural model, plus an ACT_LOW=1 / SEL_W=4 instance.
module tb_decoder_nto2n_scan;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT 0: defaults (SEL_W=3, active-high) ----------------
    logic       en, mode, sel_valid, sel_ready;
    logic [2:0] sel, cur_idx;
    logic [7:0] dwell, y;
    logic       active, wrap;

    decoder_nto2n_scan dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .sel       (sel),
        .sel_valid (sel_valid),
        .sel_ready (sel_ready),
        .dwell     (dwell),
        .y         (y),
        .cur_idx   (cur_idx),
        .active    (active),
        .wrap      (wrap)
    );

    // ---------------- DUT 1: SEL_W=4, active-low ----------------
    logic        en2, mode2, sel_valid2, sel_ready2;
    logic [3:0]  sel2, cur_idx2;
    logic [7:0]  dwell2;
    logic [15:0] y2;
    logic        active2, wrap2;

    decoder_nto2n_scan #(.SEL_W(4), .DWELL_W(8), .ACT_LOW(1)) dut_al (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en2),
        .mode      (mode2),
        .sel       (sel2),
        .sel_valid (sel_valid2),
        .sel_ready (sel_ready2),
        .dwell     (dwell2),
        .y         (y2),
        .cur_idx   (cur_idx2),
        .active    (active2),
        .wrap      (wrap2)
    );

    // ---------------- scoreboard counters ----------------
    int total = 0;
    int bad   = 0;
    int wrap_seen = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks which line is lit and how many cycles the current scan index still has.
    typedef struct {
        bit lit;      // some line is on
        bit scanning; // autonomously walking
        bit wrapped;  // this is the first cycle of index 0 after a wrap
        int idx;      // lit line
        int left;     // cycles remaining at this index while scanning
    } model_t;

    model_t m = '{lit: 0, scanning: 0, wrapped: 0, idx: 0, left: 0};

    function automatic model_t next_model(input model_t cur, input bit en_i, input bit mode_i,
                                          input bit valid_i, input int sel_i, input int dwell_i);
        model_t r;
        r = cur;
        r.wrapped = 0;
        if (!en_i) begin
            r.lit = 0;
            r.scanning = 0;
        end else if (mode_i) begin
            if (!cur.scanning) begin
                r.scanning = 1;
                r.lit = 1;
                r.idx = 0;
                r.left = dwell_i + 1;
            end else begin
                r.left = cur.left - 1;
                if (r.left == 0) begin
                    r.idx = (cur.idx + 1) % 8;
                    r.wrapped = (r.idx == 0);
                    r.left = dwell_i + 1;
                end
            end
        end else begin
            if (valid_i) begin
                r.lit = 1;
                r.idx = sel_i;
                r.scanning = 0;
            end else if (cur.scanning) begin
                r.lit = 0;
                r.scanning = 0;
            end
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m <= '{lit: 0, scanning: 0, wrapped: 0, idx: 0, left: 0};
        end else begin
            m <= next_model(m, en, mode, sel_valid, int'(sel), int'(dwell));
        end
    end

    // Compare process: every falling edge, DUT 0 against the model.
    always @(negedge clk) begin
        logic [7:0] exp_y;
        exp_y = m.lit ? 8'(1 << m.idx) : 8'h00;
        check("y",         32'(y),         32'(exp_y));
        check("cur_idx",   32'(cur_idx),   32'(m.idx));
        check("active",    32'(active),    32'(m.lit));
        check("wrap",      32'(wrap),      32'(m.wrapped));
        check("sel_ready", 32'(sel_ready), 32'(en & ~mode & rst_n));
        if (wrap) wrap_seen <= wrap_seen + 1;
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int w0;
    int guard;

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0;
        en = 1'b1; mode = 1'b0; sel = '0; sel_valid = 1'b0; dwell = '0;
        en2 = 1'b1; mode2 = 1'b0; sel2 = 4'd15; sel_valid2 = 1'b1; dwell2 = '0;

        repeat (2) tick();
        check("rst_sel_ready", 32'(sel_ready), 32'h0);
        check("rst_y",         32'(y),         32'h00);
        check("rst_active",    32'(active),    32'h0);
        check("rst_y_al",      32'(y2),        32'hFFFF);

        rst_n = 1'b1;
        #1;
        check("ready_after_rst", 32'(sel_ready), 32'h1);

        // Active-low instance: sel=15 accepted on the first edge.
        tick();
        check("al_sel15", 32'(y2), 32'h7FFF);
        sel_valid2 = 1'b0;
        en2 = 1'b0;
        tick();
        check("al_en_low", 32'(y2), 32'hFFFF);

        // Direct decode, then replace without an all-off cycle.
        sel = 3'd5; sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0;
        check("direct5_y",   32'(y),       32'h20);
        check("direct5_idx", 32'(cur_idx), 32'd5);
        tick();
        check("direct5_hold", 32'(y), 32'h20);
        sel = 3'd2; sel_valid = 1'b1;
        tick();
        sel_valid = 1'b0;
        check("direct2_y", 32'(y), 32'h04);

        // Scan with dwell=2: each index held 3 cycles, wrap at cycle 24.
        mode = 1'b1; dwell = 8'd2;
        tick();
        w0 = wrap_seen;
        check("scan_k0_y",    32'(y),    32'h01);
        check("scan_k0_wrap", 32'(wrap), 32'h0);
        repeat (2) tick();
        check("scan_k2_y", 32'(y), 32'h01);
        tick();
        check("scan_k3_y", 32'(y), 32'h02);
        repeat (20) tick();
        check("scan_k23_y", 32'(y), 32'h80);
        tick();
        check("scan_k24_y",    32'(y),    32'h01);
        check("scan_k24_wrap", 32'(wrap), 32'h1);
        check("no_wrap_before", 32'(wrap_seen - w0), 32'd0);

        // dwell 2 -> 0 during index 0: index 0 still lasts 3 cycles.
        dwell = 8'd0;
        repeat (2) tick();
        check("dwchg_k26_y", 32'(y), 32'h01);
        tick();
        check("dwchg_k27_y", 32'(y), 32'h02);
        tick();
        check("dwchg_k28_y", 32'(y), 32'h04);
        w0 = wrap_seen;
        repeat (16) tick();
        check("wrap_every_8", 32'(wrap_seen - w0), 32'd2);

        // Drop en at index 4, then restart scan.
        guard = 0;
        while (cur_idx != 3'd4 && guard < 20) begin
            tick();
            guard++;
        end
        check("reach_idx4_timeout", 32'(guard < 20), 32'h1);
        en = 1'b0;
        tick();
        check("enlow_y",      32'(y),       32'h00);
        check("enlow_idx",    32'(cur_idx), 32'd4);
        check("enlow_active", 32'(active),  32'h0);
        en = 1'b1;
        tick();
        check("restart_y",    32'(y),       32'h01);
        check("restart_idx",  32'(cur_idx), 32'd0);
        check("restart_wrap", 32'(wrap),    32'h0);

        // Leave scan: lines off, index frozen.
        repeat (2) tick();
        mode = 1'b0;
        tick();
        check("scan_exit_y",   32'(y),       32'h00);
        check("scan_exit_idx", 32'(cur_idx), 32'd2);

        // Randomized phase, checked by the compare process.
        for (int i = 0; i < 600; i++) begin
            en        = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            sel       = 3'($urandom_range(0, 7));
            sel_valid = 1'($urandom_range(0, 1));
            dwell     = 8'($urandom_range(0, 3));
            tick();
        end
        sel_valid = 1'b0;

        // Asynchronous reset between clock edges while scanning.
        en = 1'b1; mode = 1'b1; dwell = 8'd1;
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_y",      32'(y),       32'h00);
        check("async_rst_active", 32'(active),  32'h0);
        check("async_rst_idx",    32'(cur_idx), 32'd0);
        #3;
        rst_n = 1'b1;
        tick();
        check("post_rst_scan_y", 32'(y), 32'h01);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
